// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and step-counter sizing.
package div_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between a divider client (master) and the divider (slave).
interface div_iter_if #(
  parameter int WIDTH = 9
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_zero;
  logic             overflow;

  modport master (
    output start, signed_mode, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, overflow
  );

  modport slave (
    input  start, signed_mode, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, overflow
  );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract stage: shift in the next dividend bit, subtract divisor if it fits.
module div_step #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);
  logic [WIDTH+1:0] ext, diff;

  assign ext     = {rem_in, bit_in};
  // Partial remainder stays below the divisor, so the top bit of diff is a clean borrow.
  assign diff    = ext - {2'b00, dvs};
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : ext[WIDTH:0];
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, one quotient bit per cycle, signed/unsigned with zero and overflow flags.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic      clk,
  input  logic      rst_n,
  div_iter_if.slave bus
);
  localparam int              CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem, prem_nxt;
  logic [WIDTH-1:0] dq, dvs;
  logic             q_bit, neg_q, neg_r, dz, ovf;
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo, rmd;
  logic             done_r, dz_o, ovf_o;

  assign dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
  assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (prem),
    .bit_in  (dq[WIDTH-1]),
    .dvs     (dvs),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.start) nxt = (bus.divisor == '0) ? DONE : CALC;
      CALC:    if (cnt == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // dq starts as the dividend magnitude and fills with quotient bits from the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      prem   <= '0;
      dq     <= '0;
      dvs    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      ovf    <= 1'b0;
      quo    <= '0;
      rmd    <= '0;
      dz_o   <= 1'b0;
      ovf_o  <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          cnt <= '0;
          dz  <= (bus.divisor == '0);
          ovf <= bus.signed_mode && (bus.dividend == MOST_NEG) && (&bus.divisor);
          if (bus.divisor == '0) begin
            prem  <= {1'b0, bus.dividend};
            dq    <= '0;
            dvs   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
          end else begin
            prem  <= '0;
            dq    <= dvd_mag;
            dvs   <= dvs_mag;
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
          end
        end
        CALC: begin
          prem <= prem_nxt;
          dq   <= {dq[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
        end
        DONE: begin
          quo    <= neg_q ? -dq : dq;
          rmd    <= neg_r ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
          dz_o   <= dz;
          ovf_o  <= ovf;
          done_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_r;
  assign bus.quotient  = quo;
  assign bus.remainder = rmd;
  assign bus.div_zero  = dz_o;
  assign bus.overflow  = ovf_o;
endmodule
